edge_emitter: RTL

EDGE_EMITTER -- requirements
Module: edge_emitter

---
 rtl/edge_emitter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/edge_emitter.sv
// Registered edge generator: drives Q high/low or as a self-terminating pulse on request,
// enforcing a minimum hold time per level and flagging rejected requests on ERR.
module edge_emitter #(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              RISE_REQ,
    input  logic              FALL_REQ,
    input  logic              PULSE_REQ,
    input  logic [HOLD_W-1:0] HOLD,
    output logic              Q,
    output logic              RDY,
    output logic              RE,
    output logic              FE,
    output logic              ERR
);

    typedef enum logic [1:0] {
        StLowRdy,
        StHighHold,
        StHighRdy,
        StLowHold
    } state_e;

    localparam logic [HOLD_W-1:0] CntOne = HOLD_W'(1);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              auto_q, auto_d;
    logic              q_q, q_d;
    logic              re_q, re_d;
    logic              fe_q, fe_d;
    logic              err_q, err_d;

    logic rdy;
    logic any_req, multi_req;
    logic accept_rise, accept_fall;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= StLowRdy;
            cnt_q   <= '0;
            hold_q  <= '0;
            auto_q  <= 1'b0;
            q_q     <= 1'b0;
            re_q    <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            auto_q  <= auto_d;
            q_q     <= q_d;
            re_q    <= re_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        any_req     = RISE_REQ | FALL_REQ | PULSE_REQ;
        multi_req   = (RISE_REQ & FALL_REQ) | (RISE_REQ & PULSE_REQ) | (FALL_REQ & PULSE_REQ);
        accept_rise = rdy & ~multi_req & ~q_q & (RISE_REQ | PULSE_REQ);
        accept_fall = rdy & ~multi_req & q_q & FALL_REQ;

        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        auto_d  = auto_q;
        q_d     = q_q;
        re_d    = 1'b0;
        fe_d    = 1'b0;
        err_d   = 1'b0;

        if (accept_rise) begin
            q_d     = 1'b1;
            re_d    = 1'b1;
            cnt_d   = HOLD;
            hold_d  = HOLD;
            auto_d  = PULSE_REQ;
            state_d = (HOLD == '0) ? StHighRdy : StHighHold;
        end else if (accept_fall) begin
            q_d     = 1'b0;
            fe_d    = 1'b1;
            cnt_d   = HOLD;
            state_d = (HOLD == '0) ? StLowRdy : StLowHold;
        end else begin
            // Anything presented without being accepted is an error, even during auto-fall.
            err_d = any_req;
            unique case (state_q)
                StHighHold, StLowHold: begin
                    cnt_d = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = (state_q == StHighHold) ? StHighRdy : StLowRdy;
                    end
                end
                StHighRdy: begin
                    // Pulse high phase over: fall and reuse the latched hold for the low phase.
                    if (auto_q) begin
                        q_d     = 1'b0;
                        fe_d    = 1'b1;
                        auto_d  = 1'b0;
                        cnt_d   = hold_q;
                        state_d = (hold_q == '0) ? StLowRdy : StLowHold;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        // A pending auto-fall keeps the block busy even though the level hold has expired.
        rdy = (state_q == StLowRdy) | ((state_q == StHighRdy) & ~auto_q);
        RDY = rdy;
        Q   = q_q;
        RE  = re_q;
        FE  = fe_q;
        ERR = err_q;
    end

endmodule
